fetch_ctrl: RTL and testbench
=============================

FETCH_CTRL -- requirements
Module: fetch_ctrl

Interface
REQ-001 Parameter RESET_VEC, default 32'hBFC0_0000, is the first fetch address after reset.
REQ-002 clk  input  1  clock; all state updates on the rising edge.
REQ-003 rst  input  1  reset; one clock, synchronous and active-high.
REQ-004 stall  input  1  decode cannot accept; holds the presented instruction.
REQ-005 redirect  input  1  branch/JAL/JALR taken; next fetch comes from redirect_target.
REQ-006 redirect_target  input  32  redirect address; bits [1:0] are ignored and treated as 0.
REQ-007 imem_req  output  1  fetch request to instruction memory.
REQ-008 imem_addr  output  32  fetch address; always equals fetch_pc.
REQ-009 imem_gnt  input  1  memory accepts the request in this cycle (valid only while imem_req=1).
REQ-010 imem_rvalid  input  1  read data valid, at least 1 cycle after the grant.
REQ-011 imem_rdata  input  32  instruction word.
REQ-012 if_valid, if_pc[31:0], if_pcplus4[31:0], if_instr[31:0]  outputs  fetched instruction to decode.

Function
REQ-013 States: IDLE, REQ, WAIT, HOLD, DROP; at most one outstanding memory request.
REQ-014 IDLE: imem_req=0; unconditionally go to REQ the next cycle.
REQ-015 REQ: imem_req=1. Transitions, highest priority first:
  - redirect: fetch_pc<=target; if imem_gnt, go to DROP, else stay in REQ.
  - imem_gnt without redirect: go to WAIT.
REQ-016 WAIT: imem_req=0. Transitions, highest priority first:
  - rvalid with redirect: discard the data, fetch_pc<=target, go to REQ.
  - redirect only: fetch_pc<=target, go to DROP.
  - rvalid only: if_instr<=rdata, if_pc<=fetch_pc, if_valid<=1, fetch_pc<=fetch_pc+4, go to HOLD.
REQ-017 HOLD: if_valid=1 and the if_* outputs are stable. Transitions, highest priority first:
  - redirect: if_valid<=0, fetch_pc<=target, go to REQ.
  - stall: stay in HOLD.
  - otherwise: if_valid<=0, go to REQ (the instruction has been consumed).
REQ-018 DROP: imem_req=0, waits for the in-flight response.
  - rvalid: discard the data, go to REQ.
  - redirect in DROP: fetch_pc<=target, stay in DROP; redirect with rvalid in the same cycle does both.
REQ-019 if_valid never asserts for a discarded (dropped) response.
REQ-020 if_pcplus4 = if_pc + 4 combinationally; all address arithmetic is 32-bit modulo 2^32 (0xFFFF_FFFC + 4 = 0).
REQ-021 Best-case latency: REQ with gnt in cycle N, rvalid in N+1, if_valid=1 in N+2.
REQ-022 Throughput: one instruction per 3 cycles with no stall and an ideal memory.
REQ-023 stall has no effect outside HOLD.
REQ-024 imem_gnt and imem_rvalid are ignored in any state that does not expect them.

Reset
REQ-025 rst takes priority over all inputs in every state.
REQ-026 Reset values: state=IDLE, fetch_pc=RESET_VEC, imem_req=0, imem_addr=RESET_VEC, if_valid=0, if_pc=0, if_instr=0.
REQ-027 rst during WAIT or DROP abandons the in-flight request; a late rvalid arriving in IDLE or REQ is ignored.

Structure
REQ-028 Package fetch_pkg holds: the state enum (fetch_state_t), the RESET_VEC default, and the instruction width constant.
REQ-029 Single module, no sub-module; fetch_pc and the output buffer are registers inside fetch_ctrl.

Verification
REQ-030 Reset then no stall, gnt=1, rvalid one cycle after grant -> if_pc sequence BFC00000, BFC00004, BFC00008; if_valid pulses every 3rd cycle.
REQ-031 stall=1 for 4 cycles while in HOLD at if_pc=BFC00004 -> if_valid, if_pc and if_instr are unchanged for all 4 cycles; the next imem_addr is BFC00008.
REQ-032 redirect to 0x80000103 in WAIT, rvalid 2 cycles later -> that response is dropped, if_valid stays 0, the next imem_addr is 0x80000100.
REQ-033 redirect and rvalid in the same cycle in WAIT -> no if_valid, REQ on the next cycle with imem_addr equal to the target.
REQ-034 rst asserted in DROP with rvalid arriving 1 cycle after -> IDLE, then REQ at BFC00000, no if_valid.
REQ-035 redirect to 0xFFFFFFFC, then consume the fetch -> if_pcplus4=0 and the next imem_addr=0x00000000.

Source files
------------

// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction fetch controller.
package fetch_pkg;

  localparam int unsigned INSTR_W           = 32;
  localparam logic [31:0] RESET_VEC_DEFAULT = 32'hBFC0_0000;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_REQ,
    ST_WAIT,
    ST_HOLD,
    ST_DROP
  } fetch_state_t;

  // Fetch addresses are word aligned; the two low bits of any target are dropped.
  function automatic logic [31:0] align_word(input logic [31:0] addr);
    return {addr[31:2], 2'b00};
  endfunction

endpackage

// File: rtl/fetch_ctrl.sv
// Instruction fetch controller: issues one memory request at a time, buffers
// the returned word for decode, and squashes responses made stale by redirects.
module fetch_ctrl
  import fetch_pkg::*;
#(
  parameter logic [31:0] RESET_VEC = RESET_VEC_DEFAULT
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               stall,
  input  logic               redirect,
  input  logic [31:0]        redirect_target,
  output logic               imem_req,
  output logic [31:0]        imem_addr,
  input  logic               imem_gnt,
  input  logic               imem_rvalid,
  input  logic [INSTR_W-1:0] imem_rdata,
  output logic               if_valid,
  output logic [31:0]        if_pc,
  output logic [31:0]        if_pcplus4,
  output logic [INSTR_W-1:0] if_instr
);

  fetch_state_t       state_q,    state_d;
  logic [31:0]        fetch_pc_q, fetch_pc_d;
  logic               if_valid_q, if_valid_d;
  logic [31:0]        if_pc_q,    if_pc_d;
  logic [INSTR_W-1:0] if_instr_q, if_instr_d;
  logic [31:0]        target;

  assign target     = align_word(redirect_target);
  assign imem_req   = (state_q == ST_REQ);
  assign imem_addr  = fetch_pc_q;
  assign if_valid   = if_valid_q;
  assign if_pc      = if_pc_q;
  assign if_instr   = if_instr_q;
  // Modulo-2^32 wrap is intentional: 0xFFFF_FFFC + 4 yields 0.
  assign if_pcplus4 = if_pc_q + 32'd4;

  // Next-state logic: sequencing of requests, capture, and response squashing.
  always_comb begin
    // NOTE: every variable written here gets a default first so no path leaves
    // it unassigned; a missing default would infer a latch.
    state_d    = state_q;
    fetch_pc_d = fetch_pc_q;
    if_valid_d = if_valid_q;
    if_pc_d    = if_pc_q;
    if_instr_d = if_instr_q;

    unique case (state_q)
      ST_IDLE: state_d = ST_REQ;

      ST_REQ: begin
        if (redirect) begin
          // A granted request is now stale; its response must be drained.
          fetch_pc_d = target;
          state_d    = imem_gnt ? ST_DROP : ST_REQ;
        end else if (imem_gnt) begin
          state_d = ST_WAIT;
        end
      end

      ST_WAIT: begin
        if (imem_rvalid && redirect) begin
          fetch_pc_d = target;
          state_d    = ST_REQ;
        end else if (redirect) begin
          fetch_pc_d = target;
          state_d    = ST_DROP;
        end else if (imem_rvalid) begin
          if_instr_d = imem_rdata;
          if_pc_d    = fetch_pc_q;
          if_valid_d = 1'b1;
          fetch_pc_d = fetch_pc_q + 32'd4;
          state_d    = ST_HOLD;
        end
      end

      ST_HOLD: begin
        if (redirect) begin
          if_valid_d = 1'b0;
          fetch_pc_d = target;
          state_d    = ST_REQ;
        end else if (!stall) begin
          if_valid_d = 1'b0;
          state_d    = ST_REQ;
        end
      end

      ST_DROP: begin
        if (redirect) fetch_pc_d = target;
        if (imem_rvalid) state_d = ST_REQ;
      end

      default: state_d = ST_IDLE;
    endcase
  end

  // State and datapath registers with synchronous reset.
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values, independent of statement order.
    if (rst) begin
      state_q    <= ST_IDLE;
      fetch_pc_q <= RESET_VEC;
      if_valid_q <= 1'b0;
      if_pc_q    <= '0;
      if_instr_q <= '0;
    end else begin
      state_q    <= state_d;
      fetch_pc_q <= fetch_pc_d;
      if_valid_q <= if_valid_d;
      if_pc_q    <= if_pc_d;
      if_instr_q <= if_instr_d;
    end
  end

endmodule

// File: tb/tb_fetch_ctrl.sv
// Self-checking bench for fetch_ctrl: directed cycle table plus a randomized
// memory responder with an expected-instruction queue.
module tb_fetch_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic        stall;
  logic        redirect;
  logic [31:0] redirect_target;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_gnt;
  logic        imem_rvalid;
  logic [31:0] imem_rdata;
  logic        if_valid;
  logic [31:0] if_pc;
  logic [31:0] if_pcplus4;
  logic [31:0] if_instr;

  int n_cmp  = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  fetch_ctrl #(.RESET_VEC(32'hBFC0_0000)) dut (
    .clk             (clk),
    .rst             (rst),
    .stall           (stall),
    .redirect        (redirect),
    .redirect_target (redirect_target),
    .imem_req        (imem_req),
    .imem_addr       (imem_addr),
    .imem_gnt        (imem_gnt),
    .imem_rvalid     (imem_rvalid),
    .imem_rdata      (imem_rdata),
    .if_valid        (if_valid),
    .if_pc           (if_pc),
    .if_pcplus4      (if_pcplus4),
    .if_instr        (if_instr)
  );

  typedef struct {
    logic        rst;
    logic        stall;
    logic        redirect;
    logic [31:0] target;
    logic        gnt;
    logic        rvalid;
    logic [31:0] rdata;
    logic        e_req;
    logic [31:0] e_addr;
    logic        e_valid;
    logic [31:0] e_pc;
    logic [31:0] e_instr;
  } vec_t;

  typedef struct {
    logic [31:0] pc;
    logic [31:0] instr;
  } exp_t;

  vec_t vecs[$];
  exp_t sb[$];

  localparam logic [31:0] RV = 32'hBFC0_0000;
  localparam logic [31:0] I0 = 32'h0000_0013;
  localparam logic [31:0] I1 = 32'h0010_0093;
  localparam logic [31:0] I2 = 32'h0020_0113;
  localparam logic [31:0] I3 = 32'h0030_0193;
  localparam logic [31:0] I4 = 32'h0040_0213;
  localparam logic [31:0] I5 = 32'h0050_0293;
  localparam logic [31:0] JK = 32'hDEAD_BEEF;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %08h expected %08h", name, act, exp);
    end
  endtask

  task automatic v(input logic r, input logic s, input logic rd, input logic [31:0] t,
                   input logic g, input logic rv, input logic [31:0] dat,
                   input logic ereq, input logic [31:0] eaddr, input logic eval,
                   input logic [31:0] epc, input logic [31:0] einstr);
    vec_t x;
    x = '{rst: r, stall: s, redirect: rd, target: t, gnt: g, rvalid: rv, rdata: dat,
          e_req: ereq, e_addr: eaddr, e_valid: eval, e_pc: epc, e_instr: einstr};
    vecs.push_back(x);
  endtask

  function automatic logic [31:0] instr_of(input logic [31:0] a);
    return a ^ 32'h5A5A_0F0F;
  endfunction

  task automatic drive_idle();
    rst = 0; stall = 0; redirect = 0; redirect_target = '0;
    imem_gnt = 0; imem_rvalid = 0; imem_rdata = '0;
  endtask

  initial begin
    drive_idle();
    rst = 1;
    repeat (2) @(posedge clk);
    #1;

    // rst stall redir target gnt rvalid rdata | req addr valid pc instr
    v(1,0,0,0,           0,0,0,  0,RV,          0,0,0);             // 0 reset
    v(0,0,0,0,           0,0,0,  1,RV,          0,0,0);             // 1 IDLE->REQ
    v(0,0,0,0,           1,0,0,  0,RV,          0,0,0);             // 2 grant
    v(0,0,0,0,           0,1,I0, 0,RV+4,        1,RV,I0);           // 3 first fetch
    v(0,0,0,0,           0,0,0,  1,RV+4,        0,RV,I0);
    v(0,0,0,0,           1,0,0,  0,RV+4,        0,RV,I0);
    v(0,0,0,0,           0,1,I1, 0,RV+8,        1,RV+4,I1);         // 6 HOLD @BFC00004
    v(0,1,0,0,           0,0,0,  0,RV+8,        1,RV+4,I1);         // 7-10 stalled
    v(0,1,0,0,           1,0,0,  0,RV+8,        1,RV+4,I1);
    v(0,1,0,0,           0,1,JK, 0,RV+8,        1,RV+4,I1);
    v(0,1,0,0,           0,0,0,  0,RV+8,        1,RV+4,I1);
    v(0,0,0,0,           0,0,0,  1,RV+8,        0,RV+4,I1);         // 11 consumed
    v(0,0,0,0,           1,0,0,  0,RV+8,        0,RV+4,I1);
    v(0,0,0,0,           0,1,I2, 0,RV+12,       1,RV+8,I2);
    v(0,0,0,0,           0,0,0,  1,RV+12,       0,RV+8,I2);
    v(0,0,0,0,           1,0,0,  0,RV+12,       0,RV+8,I2);         // 15 WAIT
    v(0,0,1,32'h80000103,0,0,0,  0,32'h80000100,0,RV+8,I2);         // 16 redirect in WAIT
    v(0,0,0,0,           1,0,0,  0,32'h80000100,0,RV+8,I2);         // 17 gnt ignored in DROP
    v(0,0,0,0,           0,1,JK, 1,32'h80000100,0,RV+8,I2);         // 18 response dropped
    v(0,0,0,0,           1,0,0,  0,32'h80000100,0,RV+8,I2);
    v(0,0,1,32'h40000000,0,1,JK, 1,32'h40000000,0,RV+8,I2);         // 20 rvalid+redirect
    v(0,1,0,0,           1,0,0,  0,32'h40000000,0,RV+8,I2);         // 21 stall ignored in REQ
    v(0,0,0,0,           0,1,I3, 0,32'h40000004,1,32'h40000000,I3);
    v(0,0,1,32'hFFFFFFFF,0,0,0,  1,32'hFFFFFFFC,0,32'h40000000,I3); // 23 redirect in HOLD
    v(0,0,0,0,           1,0,0,  0,32'hFFFFFFFC,0,32'h40000000,I3);
    v(0,0,0,0,           0,1,I4, 0,32'h00000000,1,32'hFFFFFFFC,I4); // 25 wrap
    v(0,0,0,0,           0,0,0,  1,32'h00000000,0,32'hFFFFFFFC,I4);
    v(0,0,0,0,           1,0,0,  0,32'h00000000,0,32'hFFFFFFFC,I4);
    v(0,0,1,32'h00000100,0,0,0,  0,32'h00000100,0,32'hFFFFFFFC,I4); // 28 DROP
    v(1,0,0,0,           0,0,0,  0,RV,          0,0,0);             // 29 reset in DROP
    v(0,0,0,0,           0,1,JK, 1,RV,          0,0,0);             // 30 late rvalid in IDLE
    v(0,0,0,0,           0,1,JK, 1,RV,          0,0,0);             // 31 rvalid in REQ ignored
    v(0,0,0,0,           1,0,0,  0,RV,          0,0,0);
    v(0,0,0,0,           0,1,I5, 0,RV+4,        1,RV,I5);
    v(0,0,0,0,           0,0,0,  1,RV+4,        0,RV,I5);
    v(0,0,1,32'h00001000,1,0,0,  0,32'h00001000,0,RV,I5);           // 35 redirect+gnt in REQ
    v(0,0,1,32'h00002000,0,1,JK, 1,32'h00002000,0,RV,I5);           // 36 redirect+rvalid in DROP
    v(0,0,1,32'h00003000,0,0,0,  1,32'h00003000,0,RV,I5);           // 37 redirect w/o gnt
    v(0,0,0,0,           1,0,0,  0,32'h00003000,0,RV,I5);
    v(0,0,0,0,           0,1,I0, 0,32'h00003004,1,32'h00003000,I0);

    foreach (vecs[i]) begin
      rst = vecs[i].rst; stall = vecs[i].stall; redirect = vecs[i].redirect;
      redirect_target = vecs[i].target; imem_gnt = vecs[i].gnt;
      imem_rvalid = vecs[i].rvalid; imem_rdata = vecs[i].rdata;
      @(posedge clk);
      #1;
      check($sformatf("row%0d imem_req", i), {31'd0, imem_req}, {31'd0, vecs[i].e_req});
      check($sformatf("row%0d imem_addr", i), imem_addr, vecs[i].e_addr);
      check($sformatf("row%0d if_valid", i), {31'd0, if_valid}, {31'd0, vecs[i].e_valid});
      check($sformatf("row%0d if_pc", i), if_pc, vecs[i].e_pc);
      check($sformatf("row%0d if_pcplus4", i), if_pcplus4, vecs[i].e_pc + 32'd4);
      check($sformatf("row%0d if_instr", i), if_instr, vecs[i].e_instr);
    end

    // Randomized phase: memory with variable latency and random grants/stalls.
    begin
      logic [31:0] model_pc;
      logic [31:0] pend_addr;
      logic        outstanding;
      int          delay;
      int          delivered;
      logic        drove_rv;
      exp_t        e;

      drive_idle();
      rst = 1;
      @(posedge clk); #1;
      rst = 0;
      model_pc = RV; outstanding = 0; delay = 0; delivered = 0; pend_addr = '0;

      for (int cyc = 0; cyc < 1520; cyc++) begin
        logic draining;
        draining = (cyc >= 1500);
        stall    = draining ? 1'b0 : ($urandom_range(0, 3) == 0);
        imem_gnt = draining ? 1'b0 : ($urandom_range(0, 2) != 0);
        drove_rv = 0;
        imem_rvalid = 0;
        imem_rdata  = $urandom;
        if (outstanding) begin
          if (delay == 0) begin
            imem_rvalid = 1; imem_rdata = instr_of(pend_addr); drove_rv = 1;
          end else delay--;
        end
        if (imem_req && imem_gnt) begin
          check("grant addr", imem_addr, model_pc);
          e.pc = model_pc; e.instr = instr_of(model_pc);
          sb.push_back(e);
          pend_addr = model_pc; outstanding = 1;
          delay = $urandom_range(0, 2);
          model_pc = model_pc + 32'd4;
        end
        @(posedge clk);
        #1;
        if (drove_rv) begin
          outstanding = 0;
          check("deliver if_valid", {31'd0, if_valid}, 32'd1);
          if (sb.size() == 0) begin
            n_cmp++; n_fail++;
            $display("FAIL scoreboard: delivery with empty queue, got pc %08h", if_pc);
          end else begin
            e = sb.pop_front();
            check("deliver if_pc", if_pc, e.pc);
            check("deliver if_instr", if_instr, e.instr);
            delivered++;
          end
        end
      end
      check("scoreboard drained", sb.size(), 32'd0);
      n_cmp++;
      if (delivered < 50) begin
        n_fail++;
        $display("FAIL throughput: got %0d deliveries expected at least 50", delivered);
      end
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
